cond_logic: RTL and testbench

- Consumer end of the ALU flag interface in the multicycle ARM-subset datapath.
- Holds the architectural NZCV flag register and writes it from the ALU's {N,Z,C,V} output under per-group write enables.
- Evaluates the instruction's 4-bit condition field against the stored flags.
- Gates the controller's PC, register-file and memory write strobes with a one-cycle-delayed condition result, so later multicycle states honour the condition decided at execute.

---
 rtl/isa_pkg.sv | 32 +++
 rtl/cond_check.sv | 44 ++++
 rtl/cond_logic.sv | 67 ++++++
 tb/tb_cond_logic.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ARM-subset ISA constants: condition codes, NZCV bit positions and
// controller flag-write encodings.
package isa_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] FLAGW_NONE = 2'b00;
    localparam logic [1:0] FLAGW_CV   = 2'b01;
    localparam logic [1:0] FLAGW_NZ   = 2'b10;
    localparam logic [1:0] FLAGW_ALL  = 2'b11;

endpackage

// File: rtl/cond_check.sv
// Combinational condition-code evaluator: instruction Cond field against NZCV.
// Kept standalone so a single-cycle datapath can reuse it.
module cond_check
    import isa_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_cond_ex
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign w_n = i_flags[FLAG_N];
    assign w_z = i_flags[FLAG_Z];
    assign w_c = i_flags[FLAG_C];
    assign w_v = i_flags[FLAG_V];

    // NV has no trap in this core; it executes like AL.
    always_comb begin
        o_cond_ex = 1'b1;
        unique case (i_cond)
            COND_EQ: o_cond_ex = w_z;
            COND_NE: o_cond_ex = ~w_z;
            COND_CS: o_cond_ex = w_c;
            COND_CC: o_cond_ex = ~w_c;
            COND_MI: o_cond_ex = w_n;
            COND_PL: o_cond_ex = ~w_n;
            COND_VS: o_cond_ex = w_v;
            COND_VC: o_cond_ex = ~w_v;
            COND_HI: o_cond_ex = w_c & ~w_z;
            COND_LS: o_cond_ex = ~w_c | w_z;
            COND_GE: o_cond_ex = (w_n == w_v);
            COND_LT: o_cond_ex = (w_n != w_v);
            COND_GT: o_cond_ex = ~w_z & (w_n == w_v);
            COND_LE: o_cond_ex = w_z | (w_n != w_v);
            COND_AL: o_cond_ex = 1'b1;
            COND_NV: o_cond_ex = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// NZCV flag register, condition evaluation and condition-gated write strobes
// for the multicycle datapath controller.
module cond_logic
    import isa_pkg::*;
#(
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        Cond,
    input  logic [FLAG_W-1:0] ALUFlags,
    input  logic [1:0]        FlagW,
    input  logic              PCS,
    input  logic              NextPC,
    input  logic              RegW,
    input  logic              MemW,
    output logic              PCWrite,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic [FLAG_W-1:0] Flags,
    output logic              CondEx
);

    logic [FLAG_W-1:0] r_flags;
    logic              r_cond_ex_dly;
    logic              w_cond_ex;
    logic [1:0]        w_flag_write;
    logic              w_write_nz;
    logic              w_write_cv;

    cond_check u_cond_check (
        .i_cond    (Cond),
        .i_flags   (r_flags),
        .o_cond_ex (w_cond_ex)
    );

    assign w_flag_write = FlagW & {2{w_cond_ex}};
    assign w_write_nz   = (w_flag_write & FLAGW_NZ) != FLAGW_NONE;
    assign w_write_cv   = (w_flag_write & FLAGW_CV) != FLAGW_NONE;

    // The delayed condition carries the execute-state decision into the
    // later writeback/memory states, so it is sampled every cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_flags       <= '0;
            r_cond_ex_dly <= 1'b0;
        end else begin
            if (w_write_nz) begin
                r_flags[FLAG_N] <= ALUFlags[FLAG_N];
                r_flags[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (w_write_cv) begin
                r_flags[FLAG_C] <= ALUFlags[FLAG_C];
                r_flags[FLAG_V] <= ALUFlags[FLAG_V];
            end
            r_cond_ex_dly <= w_cond_ex;
        end
    end

    // Reset forces the strobes low even before the first clock edge clears state.
    assign PCWrite  = reset & ((PCS & r_cond_ex_dly) | NextPC);
    assign RegWrite = reset & RegW & r_cond_ex_dly;
    assign MemWrite = reset & MemW & r_cond_ex_dly;
    assign Flags    = r_flags;
    assign CondEx   = w_cond_ex;

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed scenarios plus randomized
// traffic compared each cycle against a behavioural flag/condition model.
module tb_cond_logic;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, NextPC, RegW, MemW;
    logic       PCWrite, RegWrite, MemWrite, CondEx;
    logic [3:0] Flags;

    int errors = 0;
    int checks = 0;

    logic [3:0] m_flags = 4'b0000;
    logic       m_dly = 1'b0;
    bit         model_valid = 1'b0;

    cond_logic #(.FLAG_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .NextPC   (NextPC),
        .RegW     (RegW),
        .MemW     (MemW),
        .PCWrite  (PCWrite),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .Flags    (Flags),
        .CondEx   (CondEx)
    );

    always #5 clk = ~clk;

    // ARM-style evaluation: pick a base test from Cond[3:1], invert with Cond[0].
    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c[3:1] == 3'd7) return 1'b1;
        return base ^ c[0];
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic ce;
        ce = cond_eval(Cond, m_flags);
        chk("CondEx", {3'b0, CondEx}, {3'b0, ce});
        chk("Flags", Flags, m_flags);
        chk("PCWrite", {3'b0, PCWrite}, {3'b0, reset && ((PCS && m_dly) || NextPC)});
        chk("RegWrite", {3'b0, RegWrite}, {3'b0, reset && RegW && m_dly});
        chk("MemWrite", {3'b0, MemWrite}, {3'b0, reset && MemW && m_dly});
    endtask

    task automatic apply(input logic rst, input logic [3:0] c, input logic [3:0] alu,
                         input logic [1:0] fw, input logic pcs, input logic npc,
                         input logic regw, input logic memw);
        reset = rst; Cond = c; ALUFlags = alu; FlagW = fw;
        PCS = pcs; NextPC = npc; RegW = regw; MemW = memw;
        #3;
        if (model_valid) compare_model();
    endtask

    task automatic tick();
        logic ce;
        @(posedge clk);
        ce = cond_eval(Cond, m_flags);
        if (!reset) begin
            m_flags = 4'b0000;
            m_dly   = 1'b0;
        end else begin
            if (FlagW[1] && ce) m_flags[3:2] = ALUFlags[3:2];
            if (FlagW[0] && ce) m_flags[1:0] = ALUFlags[1:0];
            m_dly = ce;
        end
        model_valid = 1'b1;
        #1;
    endtask

    initial begin
        // Reset with every strobe requested
        apply(0, 4'hE, 4'hF, 2'b11, 1, 1, 1, 1); tick();
        apply(0, 4'hE, 4'hF, 2'b11, 1, 1, 1, 1);
        chk("rst_flags", Flags, 4'b0000);
        chk("rst_pcwrite", {3'b0, PCWrite}, 4'd0);
        chk("rst_regwrite", {3'b0, RegWrite}, 4'd0);
        chk("rst_memwrite", {3'b0, MemWrite}, 4'd0);
        tick();
        apply(1, 4'h0, 4'h0, 2'b00, 0, 1, 1, 0);
        chk("release_pcwrite", {3'b0, PCWrite}, 4'd1);
        chk("release_regwrite", {3'b0, RegWrite}, 4'd0);
        tick();

        // Flag write under AL, then blocked by failing NE
        apply(1, 4'hE, 4'b0100, 2'b11, 0, 0, 0, 0); tick();
        apply(1, 4'h0, 4'b0000, 2'b00, 0, 0, 0, 0);
        chk("fw_flags", Flags, 4'b0100);
        chk("fw_eq", {3'b0, CondEx}, 4'd1);
        tick();
        apply(1, 4'h1, 4'b1000, 2'b11, 0, 0, 0, 0);
        chk("ne_fail", {3'b0, CondEx}, 4'd0);
        tick();
        apply(1, 4'hE, 4'b0000, 2'b00, 0, 0, 0, 0);
        chk("ne_hold", Flags, 4'b0100);
        tick();

        // Partial C,V write
        apply(1, 4'hE, 4'b1011, 2'b01, 0, 0, 0, 0); tick();
        apply(1, 4'hE, 4'b0000, 2'b00, 0, 0, 0, 0);
        chk("partial_cv", Flags, 4'b0111);
        tick();

        // Full sweep: every Flags value against every Cond code
        for (int f = 0; f < 16; f++) begin
            apply(1, 4'hE, f[3:0], 2'b11, 0, 0, 0, 0); tick();
            for (int c = 0; c < 16; c++) begin
                apply(1, c[3:0], 4'h0, 2'b00, 0, 0, 0, 0);
                if (f == 9 && c == 10) chk("sweep_ge", {3'b0, CondEx}, 4'd1);
                if (f == 9 && c == 12) chk("sweep_gt", {3'b0, CondEx}, 4'd1);
                if (f == 9 && c == 11) chk("sweep_lt", {3'b0, CondEx}, 4'd0);
                tick();
            end
        end

        // Delayed gating, Z=1 then Z=0
        apply(1, 4'hE, 4'b0100, 2'b11, 0, 0, 0, 0); tick();
        apply(1, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0); tick();
        apply(1, 4'h1, 4'h0, 2'b00, 1, 0, 1, 1);
        chk("dly1_reg", {3'b0, RegWrite}, 4'd1);
        chk("dly1_mem", {3'b0, MemWrite}, 4'd1);
        chk("dly1_pc", {3'b0, PCWrite}, 4'd1);
        tick();
        apply(1, 4'hE, 4'b0000, 2'b11, 0, 0, 0, 0); tick();
        apply(1, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0); tick();
        apply(1, 4'h1, 4'h0, 2'b00, 1, 0, 1, 1);
        chk("dly0_reg", {3'b0, RegWrite}, 4'd0);
        chk("dly0_mem", {3'b0, MemWrite}, 4'd0);
        chk("dly0_pc", {3'b0, PCWrite}, 4'd0);
        tick();

        // Same-edge hazard
        apply(1, 4'hE, 4'b0000, 2'b11, 0, 0, 0, 0); tick();
        apply(1, 4'h0, 4'b0100, 2'b11, 0, 0, 0, 0);
        chk("hz_eq0", {3'b0, CondEx}, 4'd0);
        tick();
        apply(1, 4'hE, 4'b0100, 2'b11, 0, 0, 0, 0);
        chk("hz_unchanged", Flags, 4'b0000);
        tick();
        apply(1, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0);
        chk("hz_flags", Flags, 4'b0100);
        chk("hz_eq1", {3'b0, CondEx}, 4'd1);
        tick();

        // Reset mid-instruction suppresses pending writes
        apply(1, 4'hE, 4'h0, 2'b00, 0, 0, 1, 1); tick();
        apply(0, 4'hE, 4'h0, 2'b00, 0, 0, 1, 1);
        chk("midrst_reg", {3'b0, RegWrite}, 4'd0);
        tick();
        apply(1, 4'hE, 4'h0, 2'b00, 0, 0, 1, 1);
        chk("postrst_reg", {3'b0, RegWrite}, 4'd0);
        chk("postrst_mem", {3'b0, MemWrite}, 4'd0);
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(31) != 0), 4'($urandom), 4'($urandom), 2'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
